// File: rtl/serial_rx_if.sv
// Receive-side bundle for serial_rx_ctrl.
// Holds the serial line, the byte handshake and the status flags.
interface serial_rx_if;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_in,
    output rx_ready,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );

  modport slave (
    input  rx_in,
    input  rx_ready,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy
  );
endinterface

// File: rtl/serial_rx_ctrl.sv
// Serial 8N1 receiver with mid-bit sampling and a one-entry output buffer.
// Raises frame_err on a bad stop bit and overrun when a good byte finds the buffer full.
module serial_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic     clk,
  input  logic     reset_n,
  serial_rx_if.slave bus
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M = CW'(H - 1);
  localparam logic [CW-1:0] FULL_M = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          busy_q;
  logic          rxs;
  logic          deliver;

  assign rxs = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bus.rx_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M) begin
          cnt_d       = '0;
          sh_d[idx_q] = rxs;
          idx_d       = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M) begin
          cnt_d = '0;
          if (rxs) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A same-cycle handshake frees the buffer in time for the new byte.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && bus.rx_ready) valid_d = 1'b0;
    if (deliver) begin
      if (!valid_q || bus.rx_ready) begin
        data_d  = sh_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Self-checking bench for serial_rx_ctrl at 16 clocks per bit.
// Frames are built from bit timing arithmetic; received bytes are matched against a queue.
module tb_serial_rx_ctrl;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  serial_rx_if bus();

  serial_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive observer: handshakes, pulse counts and rx_valid rise time.
  logic [7:0] hs[$];
  int   rise_cyc = -1;
  int   ferr_cnt = 0;
  int   ovr_cnt = 0;
  int   both_cnt = 0;
  int   ferr_run = 0;
  int   ovr_run = 0;
  int   max_run = 0;
  logic prev_v = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid && !prev_v) rise_cyc = cyc;
    prev_v = bus.rx_valid;
    if (bus.rx_valid && bus.rx_ready) hs.push_back(bus.rx_data);
    if (bus.frame_err) begin
      ferr_cnt++;
      ferr_run++;
    end else ferr_run = 0;
    if (bus.overrun) begin
      ovr_cnt++;
      ovr_run++;
    end else ovr_run = 0;
    if (ferr_run > max_run) max_run = ferr_run;
    if (ovr_run > max_run) max_run = ovr_run;
    if (bus.frame_err && bus.overrun) both_cnt++;
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Called one tick after an edge; returns the cycle in which the start bit began.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            output int n);
    n = cyc;
    bus.rx_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(CPB);
      bus.rx_in = b[k];
    end
    step(CPB);
    bus.rx_in = stop_bit;
    step(CPB);
    if (stop_bit) bus.rx_in = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    total_cnt += 5;
    if (bus.rx_data !== 8'h00) $display("FAIL rst_data: got %h want 00", bus.rx_data);
    else pass_cnt++;
    if (bus.rx_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.rx_valid);
    else pass_cnt++;
    if (bus.frame_err !== 1'b0) $display("FAIL rst_ferr: got %b want 0", bus.frame_err);
    else pass_cnt++;
    if (bus.overrun !== 1'b0) $display("FAIL rst_ovr: got %b want 0", bus.overrun);
    else pass_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy);
    else pass_cnt++;
    step(2);
    reset_n = 1'b1;
    step(3);
  endtask

  task automatic test_hold_a5();
    int n;
    int h0;
    h0 = hs.size();
    bus.rx_ready = 1'b0;
    send_frame(8'hA5, 1'b1, n);
    step(20);
    total_cnt += 4;
    if (rise_cyc != n + 155) $display("FAIL a5_latency: got cycle %0d want %0d", rise_cyc, n + 155);
    else pass_cnt++;
    if (bus.rx_data !== 8'hA5) $display("FAIL a5_data: got %h want a5", bus.rx_data);
    else pass_cnt++;
    step(30);
    if (bus.rx_valid !== 1'b1) $display("FAIL a5_hold_valid: got %b want 1", bus.rx_valid);
    else pass_cnt++;
    if (bus.rx_data !== 8'hA5) $display("FAIL a5_hold_data: got %h want a5", bus.rx_data);
    else pass_cnt++;
    bus.rx_ready = 1'b1;
    step(1);
    bus.rx_ready = 1'b0;
    total_cnt += 2;
    if (bus.rx_valid !== 1'b0) $display("FAIL a5_clear: got %b want 0", bus.rx_valid);
    else pass_cnt++;
    if (hs.size() - h0 != 1) $display("FAIL a5_handshakes: got %0d want 1", hs.size() - h0);
    else pass_cnt++;
    step(3);
  endtask

  task automatic test_glitch();
    int n;
    int f0;
    f0 = ferr_cnt;
    n = cyc;
    bus.rx_in = 1'b0;
    step(4);
    bus.rx_in = 1'b1;
    step(1);
    total_cnt += 5;
    if (bus.busy !== 1'b1) $display("FAIL glitch_busy_on: got %b want 1", bus.busy);
    else pass_cnt++;
    step(5);
    if (bus.busy !== 1'b1) $display("FAIL glitch_busy_late: got %b want 1 at cycle %0d", bus.busy, cyc - n);
    else pass_cnt++;
    step(1);
    if (bus.busy !== 1'b0) $display("FAIL glitch_busy_off: got %b want 0 at cycle %0d", bus.busy, cyc - n);
    else pass_cnt++;
    step(CPB * 11);
    if (bus.rx_valid !== 1'b0) $display("FAIL glitch_valid: got %b want 0", bus.rx_valid);
    else pass_cnt++;
    if (ferr_cnt != f0) $display("FAIL glitch_ferr: got %0d want %0d", ferr_cnt, f0);
    else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int n;
    int f0;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, n);
    step(40);
    total_cnt += 5;
    if (ferr_cnt != f0 + 1) $display("FAIL ferr_count: got %0d want %0d", ferr_cnt, f0 + 1);
    else pass_cnt++;
    if (bus.rx_valid !== 1'b0) $display("FAIL ferr_valid: got %b want 0", bus.rx_valid);
    else pass_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL ferr_busy_low: got %b want 1", bus.busy);
    else pass_cnt++;
    bus.rx_in = 1'b1;
    step(2);
    if (bus.busy !== 1'b1) $display("FAIL ferr_busy_sync: got %b want 1", bus.busy);
    else pass_cnt++;
    step(1);
    if (bus.busy !== 1'b0) $display("FAIL ferr_busy_off: got %b want 0", bus.busy);
    else pass_cnt++;
    step(5);
  endtask

  task automatic test_overrun();
    int n;
    int o0;
    int f0;
    o0 = ovr_cnt;
    f0 = ferr_cnt;
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, n);
    send_frame(8'h22, 1'b1, n);
    step(5);
    total_cnt += 5;
    if (bus.rx_data !== 8'h11) $display("FAIL ovr_data: got %h want 11", bus.rx_data);
    else pass_cnt++;
    if (bus.rx_valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", bus.rx_valid);
    else pass_cnt++;
    if (ovr_cnt != o0 + 1) $display("FAIL ovr_count: got %0d want %0d", ovr_cnt, o0 + 1);
    else pass_cnt++;
    if (ferr_cnt != f0) $display("FAIL ovr_ferr: got %0d want %0d", ferr_cnt, f0);
    else pass_cnt++;
    bus.rx_ready = 1'b1;
    step(1);
    bus.rx_ready = 1'b0;
    step(1);
    if (bus.rx_valid !== 1'b0) $display("FAIL ovr_drain: got %b want 0", bus.rx_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    logic [7:0] b;
    b = 8'h55;
    bus.rx_ready = 1'b0;
    bus.rx_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(CPB);
      bus.rx_in = b[k];
    end
    step(CPB);
    bus.rx_in = b[4];
    step(CPB / 2);
    reset_n = 1'b0;
    #1;
    total_cnt += 7;
    if (bus.rx_data !== 8'h00) $display("FAIL mid_rst_data: got %h want 00", bus.rx_data);
    else pass_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", bus.busy);
    else pass_cnt++;
    if ({bus.rx_valid, bus.frame_err, bus.overrun} !== 3'b000)
      $display("FAIL mid_rst_flags: got %b want 000", {bus.rx_valid, bus.frame_err, bus.overrun});
    else pass_cnt++;
    bus.rx_in = 1'b1;
    step(3);
    reset_n = 1'b1;
    step(CPB * 10);
    if (bus.busy !== 1'b0 || bus.rx_valid !== 1'b0)
      $display("FAIL mid_quiet: got busy %b valid %b want 0 0", bus.busy, bus.rx_valid);
    else pass_cnt++;
    send_frame(8'hC3, 1'b1, n);
    step(5);
    if (bus.rx_data !== 8'hC3) $display("FAIL mid_data: got %h want c3", bus.rx_data);
    else pass_cnt++;
    if (bus.rx_valid !== 1'b1) $display("FAIL mid_valid: got %b want 1", bus.rx_valid);
    else pass_cnt++;
    if (rise_cyc != n + 155) $display("FAIL mid_latency: got cycle %0d want %0d", rise_cyc, n + 155);
    else pass_cnt++;
    bus.rx_ready = 1'b1;
    step(2);
    bus.rx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    int h0;
    int o0;
    int f0;
    h0 = hs.size();
    o0 = ovr_cnt;
    f0 = ferr_cnt;
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_frame(8'(i), 1'b1, n);
    step(5);
    total_cnt += 3;
    if (hs.size() - h0 != 10) $display("FAIL b2b_count: got %0d want 10", hs.size() - h0);
    else pass_cnt++;
    if (ovr_cnt != o0) $display("FAIL b2b_ovr: got %0d want %0d", ovr_cnt, o0);
    else pass_cnt++;
    if (ferr_cnt != f0) $display("FAIL b2b_ferr: got %0d want %0d", ferr_cnt, f0);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      if (h0 + i < hs.size()) begin
        total_cnt++;
        if (hs[h0 + i] !== 8'(i)) $display("FAIL b2b_byte%0d: got %h want %h", i, hs[h0 + i], 8'(i));
        else pass_cnt++;
      end
    end
    bus.rx_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic bad;
    int n;
    int h0;
    int f0;
    int o0;
    int exp_ferr;
    h0 = hs.size();
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    exp_ferr = 0;
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_frame(b, !bad, n);
      if (bad) begin
        exp_ferr++;
        step($urandom_range(CPB, 3 * CPB));
        bus.rx_in = 1'b1;
        step(4);
      end else begin
        exp_q.push_back(b);
        step($urandom_range(0, 20));
      end
    end
    step(10);
    total_cnt += 3;
    if (hs.size() - h0 != exp_q.size())
      $display("FAIL rnd_count: got %0d want %0d", hs.size() - h0, exp_q.size());
    else pass_cnt++;
    if (ferr_cnt - f0 != exp_ferr) $display("FAIL rnd_ferr: got %0d want %0d", ferr_cnt - f0, exp_ferr);
    else pass_cnt++;
    if (ovr_cnt != o0) $display("FAIL rnd_ovr: got %0d want %0d", ovr_cnt, o0);
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (h0 + i < hs.size()) begin
        total_cnt++;
        if (hs[h0 + i] !== exp_q[i]) $display("FAIL rnd_byte%0d: got %h want %h", i, hs[h0 + i], exp_q[i]);
        else pass_cnt++;
      end
    end
    bus.rx_ready = 1'b0;
  endtask

  task automatic test_pulses();
    total_cnt += 2;
    if (both_cnt != 0) $display("FAIL pulse_overlap: got %0d want 0", both_cnt);
    else pass_cnt++;
    if (max_run > 1) $display("FAIL pulse_width: got %0d want 1", max_run);
    else pass_cnt++;
  endtask

  initial begin
    bus.rx_in = 1'b1;
    bus.rx_ready = 1'b0;
    test_reset();
    test_hold_a5();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_pulses();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_rx_ctrl.md
SERIAL_RX_CTRL -- requirements
Module: serial_rx_ctrl

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (even, >= 4); H = CLKS_PER_BIT/2.
REQ-002 SHALL provide port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL provide port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port rx_in  input  1  asynchronous serial line; idle high; frame = start(0), 8 data LSB first, stop(1).
REQ-005 SHALL provide port rx_data  output  8  received byte, valid while rx_valid=1.
REQ-006 SHALL provide port rx_valid  output  1  byte available to consumer.
REQ-007 SHALL provide port rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready.
REQ-008 SHALL provide port frame_err  output  1  one-cycle pulse, stop bit sampled 0.
REQ-009 SHALL provide port overrun  output  1  one-cycle pulse, good frame dropped because output buffer full.
REQ-010 SHALL provide port busy  output  1  high whenever FSM not in IDLE.

Function
REQ-011 SHALL pass rx_in through a 2-flop synchronizer (reset value 1); all FSM decisions use synchronizer output rxs only.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_IDLE, with a bit-period counter (width ceil(log2(CLKS_PER_BIT))) and a 3-bit data index.
REQ-013 IDLE: on cycle T0 where rxs=0, SHALL go to START with counter cleared; otherwise stay.
REQ-014 START: at T0+H SHALL check rxs; 0 -> DATA, counter cleared; 1 -> IDLE (glitch rejected, no error, no pulse).
REQ-015 DATA: SHALL sample data bit k (k=0..7) at T0+H+(k+1)*CLKS_PER_BIT into shift register bit k; after bit 7 go to STOP.
REQ-016 STOP: SHALL sample stop bit at T0+H+9*CLKS_PER_BIT; rxs=1 -> deliver per REQ-017/018, go IDLE; rxs=0 -> frame_err pulse next cycle, byte discarded, go WAIT_IDLE.
REQ-017 Delivery with rx_valid=0, or rx_valid=1 and rx_ready=1 same cycle: SHALL load rx_data and set rx_valid=1 in the following cycle (latency 1 clk after stop sample); no overrun.
REQ-018 Delivery with rx_valid=1 and rx_ready=0: SHALL keep rx_data/rx_valid unchanged, drop new byte, pulse overrun for exactly one cycle.
REQ-019 rx_valid SHALL stay high and rx_data stable until a cycle with rx_ready=1; rx_valid clears the following cycle unless REQ-017 reloads.
REQ-020 rx_ready while rx_valid=0 SHALL have no effect.
REQ-021 WAIT_IDLE: SHALL remain until rxs=1, then go IDLE (no new frame may start on a stuck-low line).
REQ-022 From STOP with rxs=1 SHALL return to IDLE in the next cycle so a back-to-back start bit is detected without lost frames.
REQ-023 busy SHALL be 1 in START, DATA, STOP, WAIT_IDLE; 0 in IDLE.
REQ-024 frame_err and overrun SHALL never assert in the same cycle and never for more than one cycle per frame.

Reset
REQ-025 reset_n low SHALL asynchronously force: state IDLE, counter 0, index 0, shift reg 0, sync flops 1, rx_data 0x00, rx_valid 0, frame_err 0, overrun 0, busy 0.
REQ-026 Reset mid-frame SHALL abandon the partial frame; after release, reception restarts only on a new falling edge of rxs.
REQ-027 Outputs SHALL be fully registered; no combinational path from rx_in or rx_ready to any output.

Verification (CLKS_PER_BIT=16)
REQ-028 Frame 0xA5, rx_ready=0 -> rx_valid=1, rx_data=0xA5 from cycle T0+153, held until rx_ready=1, clears next cycle.
REQ-029 rx_in low for 4 cycles then high -> no rx_valid, no frame_err, busy returns 0 by T0+9.
REQ-030 Frame 0x3C with stop bit 0, then line held low 40 cycles -> one frame_err pulse, rx_valid stays 0, busy high until line returns high.
REQ-031 Frames 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x11 retained, one overrun pulse at second frame end.
REQ-032 reset_n pulsed low during data bit 4 of 0x55, then frame 0xC3 -> all outputs 0 during reset, then rx_data=0xC3, rx_valid=1.
REQ-033 Ten back-to-back frames 0x00..0x09 with rx_ready=1 -> ten rx_valid handshakes in order, no overrun, no frame_err.
